maze_solver: RTL and testbench
==============================

// Module: maze_solver
// PURPOSE
//   Initiator for the 16x16 maze memory port (x, y, D_in, RD, WR, D_out). Performs a
//   depth-first search from cell (0,0) to cell (2^N-1, 2^N-1). Cell value 0 = open, 1 = wall.
//   Visited cells are marked by writing 1. The move sequence is kept on an internal direction
//   stack and can be read back after success. Sits between top-level control and the maze memory.
// PARAMETERS
//   N        4          coordinate width; maze is 2^N x 2^N (x = row, y = column)
//   DEPTH    (local)    2^(2N) stack entries, 2 bits each (one direction per entry)
// PORTS
//   clk       in   1     single clock; all state updates on the rising edge
//   rst       in   1     synchronous reset, active-high
//   start     in   1     one-cycle pulse; begins a solve while idle
//   x         out  N     row address to the maze memory
//   y         out  N     column address to the maze memory
//   D_in      out  1     write data to the memory; always 1 when WR=1
//   RD        out  1     read strobe
//   WR        out  1     write strobe
//   D_out     in   1     read data; combinational from memory, sampled on the edge ending an RD cycle
//   busy      out  1     solve in progress
//   done      out  1     target reached; held until next accepted start or rst
//   fail      out  1     no path exists; held until next accepted start or rst
//   path_len  out  2N+1  number of moves on the stack (stack pointer)
//   rd_idx    in   2N    path readback index (0 = first move)
//   rd_dir    out  2     stack[rd_idx], combinational; 0=N(x-1) 1=E(y+1) 2=S(x+1) 3=W(y-1)
// BEHAVIOUR
//   Reset: x=y=0, D_in=0, RD=0, WR=0, busy=done=fail=0, path_len=0, state=IDLE, cur=(0,0), dir=0.
//   Reset mid-solve aborts to IDLE on the next edge. Memory marks are not undone.
//   Invariants: RD and WR are never both 1. RD/WR are 0 outside BUSY states.
//   States:
//   IDLE:  start=1 -> clear done/fail, path_len=0, cur=(0,0), busy=1 -> CHK0.
//   CHK0:  RD=1 at (0,0). D_out=1 -> FAIL, else -> MARK.
//   MARK:  WR=1, D_in=1 at cur.
//          - If cur == (2^N-1, 2^N-1) -> DONE.
//          - Otherwise dir=0 -> TRY.
//   TRY:   nb = cur stepped by dir.
//          - If nb is out of bounds: no RD; dir<3 -> dir+1, stay; dir==3 -> BACK.
//          - Else RD=1 at nb. D_out=0 -> push dir, cur=nb, path_len+1 -> MARK.
//          - D_out=1 -> dir<3 ? dir+1 : BACK.
//   BACK:  - path_len==0 -> FAIL.
//          - Else pop p: cur steps opposite of p, path_len-1.
//          - p<3 -> dir=p+1, TRY; p==3 -> stay in BACK (pop again next cycle).
//   DONE:  done=1, busy=0, stack frozen for readback -> IDLE.
//   FAIL:  fail=1, busy=0, path_len=0 -> IDLE.
//   Handshakes and bounds:
//   - start is ignored while busy.
//   - Out-of-bounds is detected on the unsigned N-bit coordinate before the step; there is no wrap-around.
//   - Stack cannot overflow: every push enters a new unvisited cell.
//   - A solve is destructive: the maze must be reloaded before the next solve.
// TESTING
//   1 All-zero maze, start pulse -> done=1; path_len=30;
//     rd_dir[0..14]=1 (E), rd_dir[15..29]=2 (S); RD&WR never both 1.
//   2 Maze with cell (0,0)=1, start -> fail=1 within 3 cycles of start;
//     no WR pulse; path_len=0.
//   3 Open cells: column 0, row 15, and (0,1..3); all others 1.
//     -> DFS enters the east dead end, backtracks, then done=1;
//     path_len=30: rd_dir[0..14]=2 (S), rd_dir[15..29]=1 (E).
//   4 All zero except (14,15)=1 and (15,14)=1, start -> fail=1;
//     every cell except the two walls and the target was written 1; busy=0.
//   5 Start a solve; assert rst for 1 cycle after 20 cycles
//     -> next cycle all outputs at reset values.
//     Then a new start pulse, pulsed after the maze is reloaded with the test-1 maze,
//     completes as in test 1.
//   6 Pulse start again while busy in test 1 -> ignored; result identical to test 1.

Source files
------------

// File: rtl/maze_solver.sv
// maze_solver: depth-first maze search initiator with direction-stack path readback
module maze_solver #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic [N-1:0] x,
  output logic [N-1:0] y,
  output logic         D_in,
  output logic         RD,
  output logic         WR,
  input  logic         D_out,
  output logic         busy,
  output logic         done,
  output logic         fail,
  output logic [2*N:0] path_len,
  input  logic [2*N-1:0] rd_idx,
  output logic [1:0]   rd_dir
);
  localparam int DEPTH = 1 << (2*N);
  typedef enum logic [2:0] {IDLE, CHK0, MARK, TRY, BACK, DONE, FAIL} state_t;
  state_t state, state_n;
  logic [N-1:0] cx, cy, nx, ny, bx, by;
  logic [1:0] dir, p;
  logic [1:0] stack [DEPTH];
  logic oob, at_goal, empty, push, pop;
  assign oob = dir == 2'd0 ? cx == '0 : dir == 2'd1 ? cy == '1 : dir == 2'd2 ? cx == '1 : cy == '0;
  assign nx = dir == 2'd0 ? cx - 1'b1 : dir == 2'd2 ? cx + 1'b1 : cx;
  assign ny = dir == 2'd1 ? cy + 1'b1 : dir == 2'd3 ? cy - 1'b1 : cy;
  assign p = stack[path_len[2*N-1:0] - 1'b1];
  assign bx = p == 2'd0 ? cx + 1'b1 : p == 2'd2 ? cx - 1'b1 : cx;
  assign by = p == 2'd1 ? cy - 1'b1 : p == 2'd3 ? cy + 1'b1 : cy;
  assign at_goal = cx == '1 && cy == '1;
  assign empty = path_len == '0;
  assign D_in = WR;
  assign rd_dir = stack[rd_idx];
  always_comb begin
    state_n = state;
    RD = 1'b0;
    WR = 1'b0;
    x = cx;
    y = cy;
    push = 1'b0;
    pop = 1'b0;
    case (state)
      IDLE: state_n = start ? CHK0 : IDLE;
      CHK0: begin
        RD = 1'b1;
        state_n = D_out ? FAIL : MARK;
      end
      MARK: begin
        WR = 1'b1;
        state_n = at_goal ? DONE : TRY;
      end
      TRY: begin
        x = nx;
        y = ny;
        RD = !oob;
        push = !oob && !D_out;
        state_n = push ? MARK : dir == 2'd3 ? BACK : TRY;
      end
      BACK: begin
        pop = !empty;
        state_n = empty ? FAIL : p == 2'd3 ? BACK : TRY;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cx <= '0;
      cy <= '0;
      dir <= '0;
      path_len <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      fail <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        done <= 1'b0;
        fail <= 1'b0;
        busy <= 1'b1;
        path_len <= '0;
        cx <= '0;
        cy <= '0;
      end
      if (state == MARK) dir <= '0;
      if (state == TRY && !push) dir <= dir + 1'b1;
      if (push) begin
        cx <= nx;
        cy <= ny;
        path_len <= path_len + 1'b1;
      end
      if (pop) begin
        cx <= bx;
        cy <= by;
        dir <= p + 1'b1;
        path_len <= path_len - 1'b1;
      end
      if (state == DONE) begin
        done <= 1'b1;
        busy <= 1'b0;
      end
      if (state == FAIL) begin
        fail <= 1'b1;
        busy <= 1'b0;
        path_len <= '0;
      end
    end
  end
  always_ff @(posedge clk)
    if (!rst && push) stack[path_len[2*N-1:0]] <= dir;
endmodule

// File: tb/tb_maze_solver.sv
// tb_maze_solver: directed self-checking bench for maze_solver against a 16x16 memory model
module tb_maze_solver;
  logic clk = 1'b0;
  logic rst, start;
  logic [3:0] x, y;
  logic D_in, RD, WR, D_out;
  logic busy, done, fail;
  logic [8:0] path_len;
  logic [7:0] rd_idx;
  logic [1:0] rd_dir;
  logic mem [16][16];
  int tests = 0, fails = 0, both_cnt = 0, wr_cnt = 0;
  maze_solver #(.N(4)) dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .D_in(D_in), .RD(RD), .WR(WR),
    .D_out(D_out), .busy(busy), .done(done), .fail(fail), .path_len(path_len),
    .rd_idx(rd_idx), .rd_dir(rd_dir)
  );
  always #5 clk = ~clk;
  assign D_out = mem[x][y];
  always @(negedge clk) begin
    if (RD && WR) both_cnt = both_cnt + 1;
    if (WR) begin
      wr_cnt = wr_cnt + 1;
      mem[x][y] = D_in;
    end
  end
  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic fill(input logic v);
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) mem[i][j] = v;
  endtask
  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask
  task automatic wait_end(input string tag);
    int k;
    for (k = 0; k < 10000 && !(done || fail); k++) @(negedge clk);
    if (k == 10000) check({tag, "_timeout"}, 0, 1);
  endtask
  task automatic check_path(input string tag, input int d0, input int d1);
    for (int i = 0; i < 30; i++) begin
      rd_idx = 8'(i);
      #1;
      check($sformatf("%s_dir%0d", tag, i), rd_dir, i < 15 ? d0 : d1);
    end
  endtask
  task automatic check_idle(input string tag);
    check({tag, "_x"}, x, 0);
    check({tag, "_y"}, y, 0);
    check({tag, "_din"}, D_in, 0);
    check({tag, "_rd"}, RD, 0);
    check({tag, "_wr"}, WR, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_fail"}, fail, 0);
    check({tag, "_len"}, path_len, 0);
  endtask
  initial begin
    int w0, cnt, k;
    rst = 1'b1;
    start = 1'b0;
    rd_idx = '0;
    fill(1'b0);
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    pulse_start();
    check("t1_busy", busy, 1);
    wait_end("t1");
    check("t1_done", done, 1);
    check("t1_fail", fail, 0);
    check("t1_len", path_len, 30);
    repeat (5) @(negedge clk);
    check("t1_done_held", done, 1);
    check("t1_busy_low", busy, 0);
    check_path("t1", 1, 2);
    check("t1_rdwr", both_cnt, 0);
    fill(1'b0);
    mem[0][0] = 1'b1;
    w0 = wr_cnt;
    pulse_start();
    for (k = 0; k < 2 && !fail; k++) @(negedge clk);
    check("t2_fail", fail, 1);
    check("t2_done", done, 0);
    check("t2_nowr", wr_cnt - w0, 0);
    check("t2_len", path_len, 0);
    fill(1'b1);
    for (int i = 0; i < 16; i++) begin
      mem[i][0] = 1'b0;
      mem[15][i] = 1'b0;
    end
    for (int j = 1; j < 4; j++) mem[0][j] = 1'b0;
    pulse_start();
    wait_end("t3");
    check("t3_done", done, 1);
    check("t3_len", path_len, 30);
    check("t3_deadend_marked", mem[0][3], 1);
    check_path("t3", 2, 1);
    fill(1'b0);
    mem[14][15] = 1'b1;
    mem[15][14] = 1'b1;
    pulse_start();
    wait_end("t4");
    check("t4_fail", fail, 1);
    check("t4_done", done, 0);
    check("t4_busy", busy, 0);
    check("t4_len", path_len, 0);
    cnt = 0;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) cnt += mem[i][j] ? 1 : 0;
    check("t4_marked", cnt, 255);
    check("t4_target", mem[15][15], 0);
    check("t4_rdwr", both_cnt, 0);
    fill(1'b0);
    pulse_start();
    repeat (20) @(negedge clk);
    check("t5_busy_mid", busy, 1);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check_idle("t5_rst");
    fill(1'b0);
    pulse_start();
    wait_end("t5");
    check("t5_done", done, 1);
    check("t5_len", path_len, 30);
    check_path("t5", 1, 2);
    fill(1'b0);
    pulse_start();
    repeat (10) @(negedge clk);
    pulse_start();
    wait_end("t6");
    check("t6_done", done, 1);
    check("t6_fail", fail, 0);
    check("t6_len", path_len, 30);
    check_path("t6", 1, 2);
    repeat (3) @(negedge clk);
    check("t6_idle_busy", busy, 0);
    check("t6_rdwr", both_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
